// File: rtl/nif_pkg.sv
// Shared types and defaults for the multi-core NetFPGA packet buffer.
// The one-hot state codes double as the debug value seen on the top-level state port.
package nif_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_CTRL_W = 8;
  localparam int DEFAULT_ADDR_W = 8;

  // Widest ctrl lane the end-of-packet helper handles
  localparam int CTRL_MAX_W = 32;

  localparam logic [4:0] IDLE_OH = 5'b00001;
  localparam logic [4:0] RX_OH   = 5'b00010;
  localparam logic [4:0] EX_OH   = 5'b00100;
  localparam logic [4:0] TX_OH   = 5'b01000;
  localparam logic [4:0] DROP_OH = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE = IDLE_OH,
    ST_RX   = RX_OH,
    ST_EX   = EX_OH,
    ST_TX   = TX_OH,
    ST_DROP = DROP_OH
  } state_t;

  // Any nonzero ctrl value after the first word marks the end of a packet
  function automatic logic ctrl_nonzero(input logic [CTRL_MAX_W-1:0] ctrl);
    return |ctrl;
  endfunction

endpackage

// File: rtl/nif_pkt_ram.sv
// Single-port RAM holding one core's copy of the packet, with separately
// writable data and ctrl lanes and a registered read port.
module nif_pkt_ram #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic              data_we,
  input  logic              ctrl_we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CTRL_W-1:0] wctrl,
  output logic [DATA_W-1:0] rdata,
  output logic [CTRL_W-1:0] rctrl
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [CTRL_W-1:0] rctrl_q;

  always_ff @(posedge clk) begin
    if (data_we) data_mem[addr] <= wdata;
    if (ctrl_we) ctrl_mem[addr] <= wctrl;
    if (rd_en) begin
      rdata_q <= data_mem[addr];
      rctrl_q <= ctrl_mem[addr];
    end
  end

  assign rdata = rdata_q;
  assign rctrl = rctrl_q;

endmodule

// File: rtl/nif_mc_pkt_buffer.sv
// Packet buffer: replicates one ingress packet into a RAM copy per core, releases
// the cores, waits for all of them to finish, then streams core 0's copy out.
module nif_mc_pkt_buffer
  import nif_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int CTRL_W    = DEFAULT_CTRL_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int NUM_CORES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic                        in_wr,
  output logic                        in_rdy,
  output logic [DATA_W-1:0]           out_data,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic                        out_wr,
  input  logic                        out_rdy,
  input  logic [NUM_CORES-1:0]        core_en,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata,
  output logic [NUM_CORES-1:0]        core_start,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [ADDR_W-1:0]           pkt_head,
  output logic [ADDR_W:0]             pkt_len,
  output logic [15:0]                 drop_count,
  output logic [4:0]                  state
);

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           wp_q, wp_d;
  logic [ADDR_W-1:0]           rp_q, rp_d;
  logic [ADDR_W-1:0]           head_q, head_d;
  logic [ADDR_W:0]             len_q, len_d;
  logic [ADDR_W:0]             tx_left_q, tx_left_d;
  logic [15:0]                 drop_q, drop_d;
  logic [NUM_CORES-1:0]        done_q, done_d;
  logic [NUM_CORES-1:0]        core_rd_vld_q, core_rd_vld_d;
  logic                        out_wr_q, out_wr_d;
  logic [NUM_CORES*DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]           out_data_q, out_data_d;
  logic [CTRL_W-1:0]           out_ctrl_q, out_ctrl_d;

  logic                        accept;
  logic                        in_last;
  logic                        in_ex;
  logic                        ing_we;
  logic                        tx_rd;
  logic [15:0]                 drop_inc;
  logic [NUM_CORES-1:0]        core_rd;
  logic [NUM_CORES-1:0]        core_wr;
  logic [NUM_CORES*DATA_W-1:0] ram_rdata;
  logic [NUM_CORES*CTRL_W-1:0] ram_rctrl;
  logic                        unused_rctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wp_q          <= '0;
      rp_q          <= '0;
      head_q        <= '0;
      len_q         <= '0;
      tx_left_q     <= '0;
      drop_q        <= '0;
      done_q        <= '0;
      core_rd_vld_q <= '0;
      out_wr_q      <= 1'b0;
      core_rdata_q  <= '0;
      out_data_q    <= '0;
      out_ctrl_q    <= '0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      head_q        <= head_d;
      len_q         <= len_d;
      tx_left_q     <= tx_left_d;
      drop_q        <= drop_d;
      done_q        <= done_d;
      core_rd_vld_q <= core_rd_vld_d;
      out_wr_q      <= out_wr_d;
      core_rdata_q  <= core_rdata_d;
      out_data_q    <= out_data_d;
      out_ctrl_q    <= out_ctrl_d;
    end
  end

  assign accept   = in_wr & in_rdy;
  assign in_last  = ctrl_nonzero(CTRL_MAX_W'(in_ctrl));
  assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    head_d    = head_q;
    len_d     = len_q;
    tx_left_d = tx_left_q;
    drop_d    = drop_q;
    done_d    = done_q;
    ing_we    = 1'b0;
    tx_rd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ing_we  = 1'b1;
          head_d  = wp_q;
          len_d   = ONE_LEN;
          wp_d    = wp_q + 1'b1;
          state_d = ST_RX;
        end
      end
      ST_RX: begin
        if (accept) begin
          // A full copy cannot take another word; an EOP landing here ends the drop at once
          if (len_q == FULL_LEN) begin
            if (in_last) begin
              wp_d    = head_q;
              drop_d  = drop_inc;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            ing_we = 1'b1;
            wp_d   = wp_q + 1'b1;
            len_d  = len_q + 1'b1;
            if (in_last) state_d = ST_EX;
          end
        end
      end
      ST_DROP: begin
        if (accept && in_last) begin
          wp_d    = head_q;
          drop_d  = drop_inc;
          state_d = ST_IDLE;
        end
      end
      ST_EX: begin
        done_d = done_q | core_done;
        if (&done_d) begin
          done_d    = '0;
          rp_d      = head_q;
          tx_left_d = len_q;
          state_d   = ST_TX;
        end
      end
      ST_TX: begin
        if (out_rdy) begin
          tx_rd     = 1'b1;
          rp_d      = rp_q + 1'b1;
          tx_left_d = tx_left_q - 1'b1;
          if (tx_left_q == ONE_LEN) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ex   = (state_q == ST_EX);
  assign core_rd = {NUM_CORES{in_ex}} & core_en & ~core_we;
  assign core_wr = {NUM_CORES{in_ex}} & core_en & core_we;

  // Read data is shown straight from the RAM the cycle after a read, otherwise held
  always_comb begin
    in_rdy        = ~reset & (state_q inside {ST_IDLE, ST_RX, ST_DROP});
    core_start    = {NUM_CORES{in_ex & ~reset}} & ~done_q;
    core_rd_vld_d = core_rd;
    out_wr_d      = tx_rd;
    core_rdata_d  = core_rdata_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_rd_vld_q[i]) core_rdata_d[i*DATA_W +: DATA_W] = ram_rdata[i*DATA_W +: DATA_W];
    end
    out_data_d = out_wr_q ? ram_rdata[DATA_W-1:0] : out_data_q;
    out_ctrl_d = out_wr_q ? ram_rctrl[CTRL_W-1:0] : out_ctrl_q;
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_copy
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_data_we;
    logic              ram_rd;

    // Ingress owns every copy outside EX; core 0's copy also feeds egress in TX
    always_comb begin
      ram_addr    = wp_q;
      ram_wdata   = in_data;
      ram_data_we = ing_we;
      ram_rd      = 1'b0;
      if (in_ex) begin
        ram_addr    = core_addr[i*ADDR_W +: ADDR_W];
        ram_wdata   = core_wdata[i*DATA_W +: DATA_W];
        ram_data_we = core_wr[i];
        ram_rd      = core_rd[i];
      end else if (tx_rd && (i == 0)) begin
        ram_addr = rp_q;
        ram_rd   = 1'b1;
      end
    end

    nif_pkt_ram #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk    (clk),
      .rd_en  (ram_rd),
      .data_we(ram_data_we),
      .ctrl_we(ing_we),
      .addr   (ram_addr),
      .wdata  (ram_wdata),
      .wctrl  (in_ctrl),
      .rdata  (ram_rdata[i*DATA_W +: DATA_W]),
      .rctrl  (ram_rctrl[i*CTRL_W +: CTRL_W])
    );
  end

  assign unused_rctrl = ^ram_rctrl;

  assign out_wr     = out_wr_q;
  assign out_data   = out_data_d;
  assign out_ctrl   = out_ctrl_d;
  assign core_rdata = core_rdata_d;
  assign pkt_head   = head_q;
  assign pkt_len    = len_q;
  assign drop_count = drop_q;
  assign state      = state_q;

endmodule

// File: tb/tb_nif_mc_pkt_buffer.sv
// Self-checking bench for nif_mc_pkt_buffer: a packet-level model predicts the
// egress stream, ring placement and drop count; literal checks pin key values.
module tb_nif_mc_pkt_buffer;

  localparam int DATA_W    = 64;
  localparam int CTRL_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int NUM_CORES = 2;
  localparam int DEPTH     = 16;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_EX   = 5'b00100;
  localparam logic [4:0] S_TX   = 5'b01000;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [DATA_W-1:0]           in_data;
  logic [CTRL_W-1:0]           in_ctrl;
  logic                        in_wr;
  logic                        in_rdy;
  logic [DATA_W-1:0]           out_data;
  logic [CTRL_W-1:0]           out_ctrl;
  logic                        out_wr;
  logic                        out_rdy;
  logic [NUM_CORES-1:0]        core_en;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES*DATA_W-1:0] core_rdata;
  logic [NUM_CORES-1:0]        core_start;
  logic [NUM_CORES-1:0]        core_done;
  logic [ADDR_W-1:0]           pkt_head;
  logic [ADDR_W:0]             pkt_len;
  logic [15:0]                 drop_count;
  logic [4:0]                  state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words expected on egress, the packet being held, and ring bookkeeping
  logic [71:0] exp_q[$];
  logic [71:0] cur_pkt[$];
  int          model_wp    = 0;
  int          model_head  = 0;
  int          model_drops = 0;
  logic        prev_out_rdy = 1'b1;

  always #5 clk = ~clk;

  nif_mc_pkt_buffer #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .ADDR_W   (ADDR_W),
    .NUM_CORES(NUM_CORES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_wr     (in_wr),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wr    (out_wr),
    .out_rdy   (out_rdy),
    .core_en   (core_en),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_start(core_start),
    .core_done (core_done),
    .pkt_head  (pkt_head),
    .pkt_len   (pkt_len),
    .drop_count(drop_count),
    .state     (state)
  );

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every egress word must be the next word the model expects, and only after a ready cycle
  always @(negedge clk) begin
    if (!reset && out_wr) begin
      checkOutput("egress_after_ready", {71'd0, prev_out_rdy}, 72'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL egress_unexpected: got %0h, expected no word", {out_ctrl, out_data});
      end else begin
        checkOutput("egress_word", {out_ctrl, out_data}, exp_q.pop_front());
      end
    end
    prev_out_rdy = out_rdy;
  end

  // Sends one packet: ctrl 0xFF on the first word, 0x04 on the last, zero between
  task automatic applyStimulus(input int n, input logic [63:0] base);
    logic [7:0] c;
    cur_pkt.delete();
    for (int i = 0; i < n; i++) begin
      c = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h04 : 8'h00);
      in_data = base + 64'(i);
      in_ctrl = c;
      in_wr   = 1'b1;
      @(negedge clk);
      checkOutput("in_rdy_during_rx", {71'd0, in_rdy}, 72'd1);
      @(posedge clk);
      #1;
      cur_pkt.push_back({c, base + 64'(i)});
    end
    in_wr   = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    if (n <= DEPTH) begin
      model_head = model_wp;
      model_wp   = (model_wp + n) % DEPTH;
    end else begin
      model_drops++;
      cur_pkt.delete();
    end
  endtask

  task automatic commitPacket();
    foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
  endtask

  task automatic releaseCores();
    core_done = 2'b11;
    @(posedge clk);
    #1;
    core_done = 2'b00;
  endtask

  // Runs egress until the model is drained; optionally toggles out_rdy every cycle
  task automatic waitEgress(input bit toggle, input int exp_span);
    int first;
    int last;
    int k;
    first = -1;
    last  = -1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_wr) begin
        if (first < 0) first = k;
        last = k;
      end
      @(posedge clk);
      #1;
      if (toggle) out_rdy = ~out_rdy;
      if (exp_q.size() == 0 && state == S_IDLE) break;
    end
    out_rdy = 1'b1;
    if (k >= 200) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL egress_timeout: got %0d words left, expected 0", exp_q.size());
    end
    if (exp_span > 0) checkOutput("egress_span", 72'(last - first + 1), 72'(exp_span));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    in_data    = '0;
    in_ctrl    = '0;
    in_wr      = 1'b0;
    out_rdy    = 1'b1;
    core_en    = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    core_done  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_state", 72'(state), 72'(S_IDLE));
    checkOutput("rst_in_rdy", 72'(in_rdy), 72'd0);
    checkOutput("rst_out_wr", 72'(out_wr), 72'd0);
    checkOutput("rst_out_data", 72'(out_data), 72'd0);
    checkOutput("rst_core_start", 72'(core_start), 72'd0);
    checkOutput("rst_pkt_len", 72'(pkt_len), 72'd0);
    checkOutput("rst_pkt_head", 72'(pkt_head), 72'd0);
    checkOutput("rst_drop_count", 72'(drop_count), 72'd0);
    checkOutput("rst_core_rdata", 72'(^core_rdata === 1'bx), 72'd0);
    checkOutput("rst_core_rdata_lo", 72'(core_rdata[63:0]), 72'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] 4-word packet, both cores done together");
    applyStimulus(4, 64'hA0);
    @(negedge clk);
    checkOutput("t1_state_ex", 72'(state), 72'(S_EX));
    checkOutput("t1_core_start", 72'(core_start), 72'h3);
    checkOutput("t1_pkt_len", 72'(pkt_len), 72'd4);
    checkOutput("t1_pkt_head", 72'(pkt_head), 72'd0);
    commitPacket();
    releaseCores();
    waitEgress(1'b0, 4);

    $display("[TB] staggered core_done");
    applyStimulus(3, 64'hB0);
    commitPacket();
    for (int c = 0; c <= 10; c++) begin
      core_done = (c == 3) ? 2'b10 : ((c == 10) ? 2'b01 : 2'b00);
      @(negedge clk);
      checkOutput("t2_core_start", 72'(core_start), (c <= 3) ? 72'h3 : 72'h1);
      checkOutput("t2_state_ex", 72'(state), 72'(S_EX));
      @(posedge clk);
      #1;
    end
    core_done = 2'b00;
    @(negedge clk);
    checkOutput("t2_state_tx", 72'(state), 72'(S_TX));
    checkOutput("t2_pkt_head", 72'(pkt_head), 72'd4);
    waitEgress(1'b0, 3);

    $display("[TB] core 0 rewrites word 2 of its copy");
    applyStimulus(4, 64'hC0);
    checkOutput("t3_pkt_head_model", 72'(pkt_head), 72'(model_head));
    core_en    = 2'b11;
    core_we    = 2'b01;
    core_addr  = {ADDR_W'(model_head + 1), ADDR_W'(model_head + 1)};
    core_wdata = {64'd0, 64'hDEADBEEF};
    cur_pkt[1][63:0] = 64'hDEADBEEF;
    @(posedge clk);
    #1;
    core_en = 2'b01;
    core_we = 2'b00;
    @(posedge clk);
    #1;
    core_en = 2'b00;
    @(negedge clk);
    checkOutput("t3_core0_rdata", 72'(core_rdata[63:0]), 72'hDEADBEEF);
    checkOutput("t3_core1_rdata", 72'(core_rdata[127:64]), 72'hC1);
    commitPacket();
    @(posedge clk);
    #1;
    releaseCores();
    waitEgress(1'b0, 4);
    checkOutput("t3_core0_rdata_held", 72'(core_rdata[63:0]), 72'hDEADBEEF);

    $display("[TB] oversize packet then a short one");
    applyStimulus(20, 64'hD0);
    @(negedge clk);
    checkOutput("t4_drop_count", 72'(drop_count), 72'd1);
    checkOutput("t4_state_idle", 72'(state), 72'(S_IDLE));
    @(posedge clk);
    #1;
    applyStimulus(3, 64'hE0);
    @(negedge clk);
    checkOutput("t4_pkt_head", 72'(pkt_head), 72'd11);
    checkOutput("t4_pkt_head_model", 72'(pkt_head), 72'(model_head));
    commitPacket();
    releaseCores();
    waitEgress(1'b0, 3);

    $display("[TB] ring wrap with out_rdy toggling");
    applyStimulus(5, 64'hF0);
    @(negedge clk);
    checkOutput("t5_pkt_head", 72'(pkt_head), 72'd14);
    checkOutput("t5_pkt_len", 72'(pkt_len), 72'd5);
    commitPacket();
    releaseCores();
    waitEgress(1'b1, 0);

    $display("[TB] reset in the middle of a packet");
    in_wr   = 1'b1;
    in_data = 64'h100;
    in_ctrl = 8'hFF;
    @(posedge clk);
    #1;
    in_data = 64'h101;
    in_ctrl = 8'h00;
    @(posedge clk);
    #1;
    in_data = 64'h102;
    reset   = 1'b1;
    @(negedge clk);
    checkOutput("t6_in_rdy_reset", 72'(in_rdy), 72'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    in_wr   = 1'b0;
    in_data = '0;
    model_wp    = 0;
    model_drops = 0;
    @(negedge clk);
    checkOutput("t6_state_idle", 72'(state), 72'(S_IDLE));
    checkOutput("t6_core_start", 72'(core_start), 72'd0);
    checkOutput("t6_out_wr", 72'(out_wr), 72'd0);
    checkOutput("t6_pkt_len", 72'(pkt_len), 72'd0);
    checkOutput("t6_drop_count", 72'(drop_count), 72'd0);
    @(posedge clk);
    #1;
    applyStimulus(3, 64'h200);
    @(negedge clk);
    checkOutput("t6_pkt_head", 72'(pkt_head), 72'd0);
    checkOutput("t6_pkt_len_new", 72'(pkt_len), 72'd3);
    commitPacket();
    releaseCores();
    waitEgress(1'b0, 3);
    checkOutput("final_drop_count", 72'(drop_count), 72'(model_drops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nif_mc_pkt_buffer.md
# nif_mc_pkt_buffer

Parametrised network-interface packet buffer, successor to the two-core NetFPGA FIFO/FSM. Sits between the NetFPGA datapath (in_*/out_*) and NUM_CORES processor cores. Accepts one packet, replicates it into a private RAM copy per core, releases the cores to process it in place, waits for every core to signal done, then streams core 0's copy back out. Adds oversize-packet drop, ring-pointer wrap, and a per-core done barrier.

## Interface
Parameters:
- DATA_W, 64, data lane width.
- CTRL_W, 8, NetFPGA control lane width.
- ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W words.
- NUM_CORES, 2, number of core copies (1..8).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_data / in_ctrl / in_wr  in  DATA_W / CTRL_W / 1  ingress word; accepted when in_wr & in_rdy.
- in_rdy  out  1  ingress ready.
- out_data / out_ctrl / out_wr  out  DATA_W / CTRL_W / 1  egress word, valid when out_wr.
- out_rdy  in  1  downstream ready.
- core_en  in  NUM_CORES  per-core RAM enable.
- core_we  in  NUM_CORES  per-core write enable.
- core_addr  in  NUM_CORES*ADDR_W  packed per-core addresses, core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed per-core write data.
- core_rdata  out  NUM_CORES*DATA_W  packed per-core read data, 1-cycle latency.
- core_start  out  NUM_CORES  packet ready for core i.
- core_done  in  NUM_CORES  core i has finished.
- pkt_head  out  ADDR_W  address of first word of current packet.
- pkt_len  out  ADDR_W+1  stored word count, 1..DEPTH.
- drop_count  out  16  dropped oversize packets, saturating.
- state  out  5  one-hot FSM state, for debug.

## Operation
- States: IDLE=00001, RX=00010, EX=00100, TX=01000, DROP=10000.
- IDLE: in_rdy=1. On accept, write {ctrl,data} at wp in all copies, set pkt_head=wp, set pkt_len=1, wp++, go to RX. The first word is stored whatever its ctrl value.
- RX: in_rdy=1. Each accepted word is written at wp in all copies; wp++ and pkt_len++.
  - A word with nonzero in_ctrl is the last word; go to EX.
  - If a zero-ctrl word arrives when pkt_len==DEPTH, go to DROP. That word is not written.
- DROP: in_rdy=1. Discard words up to and including the next nonzero-ctrl word. Then set wp=pkt_head, drop_count++ (saturating), and go to IDLE.
- EX: in_rdy=0.
  - core_start[i] = (state==EX) & ~done_q[i].
  - done_q[i] is set when core_done[i] is high in EX, including the entry cycle.
  - Core i owns its own copy through core_en/core_we/core_addr/core_wdata.
  - Core writes update the data lane only. The ctrl lane is written only by RX.
  - When all done_q bits are set, clear done_q and go to TX.
- TX: in_rdy=0; rp starts at pkt_head.
  - Each cycle with out_rdy=1 and words remaining: read core 0's copy at rp, then rp++.
  - The next cycle has out_wr=1 with that word; out_ctrl comes from the ctrl lane.
  - After the last read, go to IDLE. The final out_wr therefore occurs in the first IDLE cycle.
- Outside EX, core_rdata holds its last value and core writes are ignored.
- Arithmetic: wp and rp are ADDR_W bits and wrap modulo DEPTH. The next packet starts at the wp left by the previous one.
- Reset (also mid-packet):
  - Returns the FSM to IDLE.
  - Clears to 0: wp, rp, pkt_head, pkt_len, drop_count, done_q, out_wr, out_data, out_ctrl, core_rdata.
  - core_start=0; in_rdy=0 while reset is high.
  - RAM contents are not cleared.

## Timing
- Ingress: write into RAM in the accept cycle; state changes on the next edge.
- Last ingress word to core_start high: 1 cycle.
- Last core_done to first TX read: 1 cycle. First out_wr follows 1 cycle later.
- Egress throughput is 1 word/cycle while out_rdy=1. When out_rdy=0, no read is issued and out_wr=0 next cycle; no word is lost or repeated.
- core_rdata is valid the cycle after core_en=1 with core_we=0.

## Structure
- Package nif_pkg holds:
  - state localparams and state type;
  - default DATA_W, CTRL_W, ADDR_W;
  - ctrl_nonzero helper function.
- Sub-module nif_pkt_ram:
  - one instance per core via generate;
  - single-port synchronous-read RAM;
  - separate data (DATA_W) and ctrl (CTRL_W) arrays with separate write enables.
- The FSM, pointers and port muxing live in the top.

## Test plan
- 4-word packet, ctrl 0xFF/0x00/0x00/0x04, NUM_CORES=2, both cores done at once -> core_start high 1 cycle after word 4. Egress gives the same 4 words with out_wr on 4 consecutive cycles; pkt_len=4.
- Staggered done: core 1 done 3 cycles, core 0 done 10 cycles after EX entry -> core_start[1] drops after cycle 3. TX begins only after core_done[0].
- Core 0 writes 0xDEADBEEF at pkt_head+1 in EX -> egress word 2 data=0xDEADBEEF, ctrl=0x00 unchanged. Core 1's copy holds the original word.
- ADDR_W=4, 20-word packet -> 16 words stored, remainder discarded through EOP. drop_count=1, wp back to pkt_head, next 3-word packet forwarded intact.
- Ring wrap: wp=14 with ADDR_W=4, 5-word packet -> stored at 14,15,0,1,2 and egress order correct. out_rdy toggling 1/0 during TX -> no duplicate or missing words.
- reset asserted mid-RX on word 3 -> next cycle state=IDLE, wp=0, core_start=0, out_wr=0. A fresh packet then processes normally.
